pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, PC and address width; RAS_DEPTH, 4, return-address-stack entries; RESET_PC, 0, PC value after reset.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin fetching from IDLE.
REQ-005 stall  input  1  pause fetch after the current request completes.
REQ-006 halt  input  1  stop fetching; sampled with imem_ack.
REQ-007 branch_valid  input  1  take branch_target; sampled with imem_ack.
REQ-008 call  input  1  push return address and jump to branch_target; sampled with imem_ack.
REQ-009 ret  input  1  pop the return-address stack and jump to the popped address; sampled with imem_ack.
REQ-010 branch_target  input  WIDTH  branch or call destination.
REQ-011 imem_ack  input  1  instruction memory accepted the current request.
REQ-012 imem_req  output  1  fetch request.
REQ-013 imem_addr  output  WIDTH  fetch address; always equals pc.
REQ-014 pc  output  WIDTH  current program counter.
REQ-015 busy  output  1  high in FETCH or STALL.
REQ-016 ras_overflow  output  1  sticky flag: call made while the stack was full.
REQ-017 ras_underflow  output  1  sticky flag: ret made while the stack was empty.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, FETCH, STALL and HALT.
REQ-019 IDLE: imem_req=0; start=1 SHALL move the FSM to FETCH on the next edge.
REQ-020 FETCH: imem_req=1, and imem_addr SHALL stay stable until the cycle in which imem_ack=1.
REQ-021 In FETCH without imem_ack, pc SHALL hold and the FSM SHALL stay in FETCH regardless of stall, halt, branch_valid, call or ret.
REQ-022 On FETCH with imem_ack, the next pc SHALL be chosen by priority: halt (pc holds) > ret > call > branch_valid > pc+1.
REQ-023 On FETCH with imem_ack, the next state SHALL be HALT if halt=1, else STALL if stall=1, else FETCH, so back-to-back fetches run at 1 per cycle when memory acks every cycle.
REQ-024 ret: pc SHALL load the stack top and the stack SHALL pop; if the stack is empty, pc SHALL load pc+1 and ras_underflow SHALL be set.
REQ-025 call: the stack SHALL push pc+1 and pc SHALL load branch_target; if the stack is full, the oldest entry SHALL be discarded and ras_overflow SHALL be set.
REQ-026 When call and ret are asserted together, ret SHALL win and the call SHALL be ignored, with no push.
REQ-027 pc+1 SHALL wrap modulo 2^WIDTH (all-ones to 0), and a pushed return address SHALL wrap the same way.
REQ-028 STALL: imem_req=0 and pc SHALL hold; stall=0 SHALL return the FSM to FETCH on the next edge.
REQ-029 HALT: imem_req=0, pc SHALL hold, and start SHALL be ignored; only reset SHALL exit HALT.
REQ-030 The ras_overflow and ras_underflow flags SHALL clear only on reset.

Reset
REQ-031 Reset SHALL be synchronous and active-high, and SHALL override all other inputs in the same edge, including mid-request in FETCH.
REQ-032 Reset values SHALL be: pc=RESET_PC, imem_req=0, busy=0, ras_overflow=0, ras_underflow=0, stack empty, state IDLE.

Structure
REQ-033 Package pc_seq_pkg SHALL hold the state enum type and the default WIDTH and RAS_DEPTH constants.
REQ-034 Sub-module ret_addr_stack SHALL implement a circular LIFO with push, pop, top, full and empty, using a drop-oldest policy on push when full.
REQ-035 Next-pc selection and FSM next-state SHALL be combinational, and all state SHALL be registered.

Verification
REQ-036 Reset, then start=1, with imem_ack tied to 1 -> pc SHALL be 0,1,2,3 on consecutive cycles with imem_req=1.
REQ-037 imem_ack held at 0 for 3 cycles at pc=5, with stall=1 and branch_valid=1 -> imem_req=1 and pc=5 SHALL hold; on ack with branch_target=0x40 -> pc=0x40 and state STALL.
REQ-038 Calls at pc=0x10 and pc=0x20 (targets 0x20, 0x30), then ret twice -> pc SHALL be 0x21 then 0x11; a third ret -> pc+1 and ras_underflow=1.
REQ-039 Five nested calls with RAS_DEPTH=4 -> ras_overflow=1, and four rets SHALL return to the last four return addresses in reverse order.
REQ-040 pc=0xFFFFFFFF with ack -> pc=0; call at 0xFFFFFFFF SHALL push 0.
REQ-041 halt with ack at pc=7 -> HALT, pc=7, imem_req=0 and start ignored; reset asserted mid-FETCH -> IDLE and pc=RESET_PC on the next edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared definitions for the PC sequencer slice: the fetch FSM state type
// and the default PC width and return-address-stack depth.
package pc_seq_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the control inputs and the instruction-fetch bus of the PC sequencer.
//   master : the sequencer itself (drives imem_req/imem_addr/pc/busy/flags,
//            receives start/stall/halt/branch_valid/call/ret/branch_target/imem_ack)
//   slave  : the core control logic and instruction memory on the other side
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             stall;
  logic             halt;
  logic             branch_valid;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] branch_target;
  logic             imem_ack;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] pc;
  logic             busy;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    input  start, stall, halt, branch_valid, call, ret, branch_target, imem_ack,
    output imem_req, imem_addr, pc, busy, ras_overflow, ras_underflow
  );

  modport slave (
    output start, stall, halt, branch_valid, call, ret, branch_target, imem_ack,
    input  imem_req, imem_addr, pc, busy, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/ret_addr_stack.sv
// ret_addr_stack
// Circular return-address LIFO. A push onto a full stack overwrites the
// oldest entry, so the most recent DEPTH return addresses are always kept.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (empties the stack)
//   push        : write push_data as the new top
//   pop         : discard the top entry (ignored when empty; wins over push)
//   push_data   : return address to store
//   top         : current top entry (meaningful only when !empty)
//   full, empty : occupancy status
module ret_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] sp_reg, sp_next, sp_inc, sp_dec;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] entry_reg [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic             do_pop, do_push;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  // sp_reg always points at the top entry; it never leaves 0..DEPTH-1.
  assign top   = entry_reg[sp_reg];

  assign sp_inc = (sp_reg == PTR_W'(DEPTH - 1)) ? '0 : sp_reg + PTR_W'(1);
  assign sp_dec = (sp_reg == '0) ? PTR_W'(DEPTH - 1) : sp_reg - PTR_W'(1);

  assign do_pop  = pop && !empty;
  assign do_push = push && !do_pop;

  always_comb begin
    sp_next    = sp_reg;
    count_next = count_reg;
    if (do_pop) begin
      sp_next    = sp_dec;
      count_next = count_reg - CNT_W'(1);
    end else if (do_push) begin
      // When full, advancing the pointer lands on the oldest slot, which the
      // write below overwrites; the count saturates at DEPTH.
      sp_next = sp_inc;
      if (!full) begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_reg    <= '0;
      count_reg <= '0;
    end else begin
      sp_reg    <= sp_next;
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (sp_inc == PTR_W'(gi));
    end
  endgenerate

  // Entry contents need no reset: occupancy is tracked by count_reg.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        entry_reg[i] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Instruction-fetch program-counter sequencer with a return-address stack.
// FSM: IDLE -> FETCH on start; FETCH issues imem_req at pc and advances only
// when imem_ack arrives; STALL pauses between requests; HALT is terminal
// until reset.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : pc_sequencer_if master modport (controls in, fetch bus and
//                status out)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               RAS_DEPTH = DEFAULT_RAS_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  seq_state_t       state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next, pc_plus1;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             ras_push, ras_pop, ras_full, ras_empty;
  logic [WIDTH-1:0] ras_top;

  // Natural WIDTH-bit truncation gives the all-ones -> 0 wrap, for both the
  // sequential pc and the pushed return address.
  assign pc_plus1 = pc_reg + WIDTH'(1);

  ret_addr_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // Nothing moves until the memory accepts the current address.
        if (bus.imem_ack) begin
          if (bus.halt) begin
            state_next = ST_HALT;
          end else begin
            if (bus.ret) begin
              // ret outranks call, so a simultaneous call is dropped entirely.
              if (ras_empty) begin
                pc_next  = pc_plus1;
                unf_next = 1'b1;
              end else begin
                pc_next = ras_top;
                ras_pop = 1'b1;
              end
            end else if (bus.call) begin
              pc_next  = bus.branch_target;
              ras_push = 1'b1;
              if (ras_full) begin
                ovf_next = 1'b1;
              end
            end else if (bus.branch_valid) begin
              pc_next = bus.branch_target;
            end else begin
              pc_next = pc_plus1;
            end
            state_next = bus.stall ? ST_STALL : ST_FETCH;
          end
        end
      end

      ST_STALL: begin
        if (!bus.stall) begin
          state_next = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign bus.imem_req      = (state_reg == ST_FETCH);
  assign bus.busy          = (state_reg == ST_FETCH) || (state_reg == ST_STALL);
  assign bus.pc            = pc_reg;
  assign bus.imem_addr     = pc_reg;
  assign bus.ras_overflow  = ovf_reg;
  assign bus.ras_underflow = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. Each fetch-cycle stimulus pushes the
// pc expected after the edge onto a scoreboard queue; the queue is popped and
// compared once the edge has happened.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct {
    logic        ack;
    logic        br;
    logic        cl;
    logic        rt;
    logic        hl;
    logic        st;
    logic [31:0] tgt;
    logic [31:0] exp;
  } op_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];
  logic [31:0] got_pc;
  logic [31:0] want_pc;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH     (32),
    .RAS_DEPTH (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.halt          = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.branch_target = '0;
    bus.imem_ack      = 1'b0;
  endtask

  // Drive one cycle of fetch-side inputs and record the pc expected after it.
  task automatic apply(input op_t o);
    bus.imem_ack      = o.ack;
    bus.branch_valid  = o.br;
    bus.call          = o.cl;
    bus.ret           = o.rt;
    bus.halt          = o.hl;
    bus.stall         = o.st;
    bus.branch_target = o.tgt;
    exp_q.push_back(o.exp);
    step();
  endtask

  // Reset, then start: leaves the DUT in FETCH at pc 0 with a clean stack.
  task automatic restart();
    clear_inputs();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Jump to x with a branch on an acked fetch.
  task automatic goto_pc(input logic [31:0] x);
    op_t o;
    o = '{ack: 1'b1, br: 1'b1, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: x, exp: x};
    apply(o);
    got_pc  = bus.pc;
    want_pc = exp_q.pop_front();
    checks++;
    if (got_pc !== want_pc) begin
      errors++;
      $display("FAIL goto_pc: pc got 0x%h want 0x%h", got_pc, want_pc);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.start    = 1'b1;
    bus.imem_ack = 1'b1;
    reset        = 1'b1;
    step();
    checks++;
    if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got 0x%h want 0x0", bus.pc); end
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.ras_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ras_overflow); end
    checks++;
    if (bus.ras_underflow !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b want 0", bus.ras_underflow); end
    $display("reset: pc=0x%h req=%b busy=%b", bus.pc, bus.imem_req, bus.busy);
    clear_inputs();
  endtask

  task automatic test_sequential();
    op_t o;
    clear_inputs();
    reset = 1'b1;
    step();
    reset        = 1'b0;
    bus.start    = 1'b1;
    bus.imem_ack = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.pc !== 32'h0 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL seq_first: pc/req got 0x%h/%b want 0x0/1", bus.pc, bus.imem_req);
    end
    for (int i = 1; i <= 3; i++) begin
      o = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h0, exp: 32'(i)};
      apply(o);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc || bus.imem_req !== 1'b1) begin
        errors++;
        $display("FAIL seq_step: pc/req got 0x%h/%b want 0x%h/1", got_pc, bus.imem_req, want_pc);
      end
      $display("seq: pc=0x%h req=%b", got_pc, bus.imem_req);
    end
  endtask

  task automatic test_wait_stall();
    op_t o;
    restart();
    goto_pc(32'h5);
    for (int i = 0; i < 3; i++) begin
      o = '{ack: 1'b0, br: 1'b1, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b1, tgt: 32'h40, exp: 32'h5};
      apply(o);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc || bus.imem_req !== 1'b1 || bus.imem_addr !== want_pc) begin
        errors++;
        $display("FAIL wait_hold: pc/addr/req got 0x%h/0x%h/%b want 0x%h/0x%h/1",
                 got_pc, bus.imem_addr, bus.imem_req, want_pc, want_pc);
      end
      $display("wait: pc=0x%h req=%b", got_pc, bus.imem_req);
    end
    o = '{ack: 1'b1, br: 1'b1, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b1, tgt: 32'h40, exp: 32'h40};
    apply(o);
    got_pc  = bus.pc;
    want_pc = exp_q.pop_front();
    checks++;
    if (got_pc !== want_pc || bus.busy !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_to_stall: pc/busy/req got 0x%h/%b/%b want 0x%h/1/0",
               got_pc, bus.busy, bus.imem_req, want_pc);
    end
    o = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b1, tgt: 32'h0, exp: 32'h40};
    apply(o);
    got_pc  = bus.pc;
    want_pc = exp_q.pop_front();
    checks++;
    if (got_pc !== want_pc || bus.imem_req !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: pc/req/busy got 0x%h/%b/%b want 0x%h/0/1",
               got_pc, bus.imem_req, bus.busy, want_pc);
    end
    o = '{ack: 1'b0, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h0, exp: 32'h40};
    apply(o);
    got_pc  = bus.pc;
    want_pc = exp_q.pop_front();
    checks++;
    if (got_pc !== want_pc || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume: pc/req got 0x%h/%b want 0x%h/1", got_pc, bus.imem_req, want_pc);
    end
    $display("stall: resumed pc=0x%h req=%b", got_pc, bus.imem_req);
  endtask

  task automatic test_call_ret();
    op_t ops[5];
    restart();
    goto_pc(32'h10);
    ops[0] = '{ack: 1'b1, br: 1'b0, cl: 1'b1, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h20, exp: 32'h20};
    ops[1] = '{ack: 1'b1, br: 1'b0, cl: 1'b1, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h30, exp: 32'h30};
    ops[2] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b1, hl: 1'b0, st: 1'b0, tgt: 32'h0,  exp: 32'h21};
    ops[3] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b1, hl: 1'b0, st: 1'b0, tgt: 32'h0,  exp: 32'h11};
    ops[4] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b1, hl: 1'b0, st: 1'b0, tgt: 32'h0,  exp: 32'h12};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++;
        if (bus.ras_underflow !== 1'b0) begin
          errors++;
          $display("FAIL unf_early: ras_underflow got %b want 0", bus.ras_underflow);
        end
      end
      apply(ops[i]);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc) begin
        errors++;
        $display("FAIL call_ret[%0d]: pc got 0x%h want 0x%h", i, got_pc, want_pc);
      end
      $display("call_ret[%0d]: pc=0x%h", i, got_pc);
    end
    checks++;
    if (bus.ras_underflow !== 1'b1 || bus.ras_overflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_flag: unf/ovf got %b/%b want 1/0", bus.ras_underflow, bus.ras_overflow);
    end
  endtask

  task automatic test_overflow();
    op_t o;
    logic [31:0] ret_exp[5];
    restart();
    goto_pc(32'h100);
    for (int i = 0; i < 5; i++) begin
      o = '{ack: 1'b1, br: 1'b0, cl: 1'b1, rt: 1'b0, hl: 1'b0, st: 1'b0,
            tgt: 32'h200 + 32'(i) * 32'h100, exp: 32'h200 + 32'(i) * 32'h100};
      apply(o);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc || bus.ras_overflow !== (i == 4)) begin
        errors++;
        $display("FAIL ovf_call[%0d]: pc/ovf got 0x%h/%b want 0x%h/%b",
                 i, got_pc, bus.ras_overflow, want_pc, (i == 4));
      end
      $display("ovf_call[%0d]: pc=0x%h ovf=%b", i, got_pc, bus.ras_overflow);
    end
    // Oldest return address (0x101) was dropped; the fifth ret underflows.
    ret_exp = '{32'h501, 32'h401, 32'h301, 32'h201, 32'h202};
    for (int i = 0; i < 5; i++) begin
      o = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b1, hl: 1'b0, st: 1'b0, tgt: 32'h0, exp: ret_exp[i]};
      apply(o);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc || bus.ras_underflow !== (i == 4)) begin
        errors++;
        $display("FAIL ovf_ret[%0d]: pc/unf got 0x%h/%b want 0x%h/%b",
                 i, got_pc, bus.ras_underflow, want_pc, (i == 4));
      end
      $display("ovf_ret[%0d]: pc=0x%h unf=%b", i, got_pc, bus.ras_underflow);
    end
    checks++;
    if (bus.ras_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ras_overflow got %b want 1", bus.ras_overflow);
    end
  endtask

  task automatic test_call_and_ret();
    op_t ops[3];
    restart();
    goto_pc(32'h50);
    ops[0] = '{ack: 1'b1, br: 1'b0, cl: 1'b1, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h60, exp: 32'h60};
    ops[1] = '{ack: 1'b1, br: 1'b1, cl: 1'b1, rt: 1'b1, hl: 1'b0, st: 1'b0, tgt: 32'h99, exp: 32'h51};
    ops[2] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b1, hl: 1'b0, st: 1'b0, tgt: 32'h0,  exp: 32'h52};
    for (int i = 0; i < 3; i++) begin
      apply(ops[i]);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc) begin
        errors++;
        $display("FAIL call_and_ret[%0d]: pc got 0x%h want 0x%h", i, got_pc, want_pc);
      end
      $display("call_and_ret[%0d]: pc=0x%h", i, got_pc);
    end
    checks++;
    if (bus.ras_underflow !== 1'b1 || bus.ras_overflow !== 1'b0) begin
      errors++;
      $display("FAIL call_and_ret_flags: unf/ovf got %b/%b want 1/0", bus.ras_underflow, bus.ras_overflow);
    end
  endtask

  task automatic test_wrap();
    op_t ops[3];
    restart();
    goto_pc(32'hFFFF_FFFF);
    ops[0] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h0,         exp: 32'h0};
    ops[1] = '{ack: 1'b1, br: 1'b1, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
    ops[2] = '{ack: 1'b1, br: 1'b0, cl: 1'b1, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h10,        exp: 32'h10};
    for (int i = 0; i < 3; i++) begin
      apply(ops[i]);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc) begin
        errors++;
        $display("FAIL wrap[%0d]: pc got 0x%h want 0x%h", i, got_pc, want_pc);
      end
      $display("wrap[%0d]: pc=0x%h", i, got_pc);
    end
    apply('{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b1, hl: 1'b0, st: 1'b0, tgt: 32'h0, exp: 32'h0});
    got_pc  = bus.pc;
    want_pc = exp_q.pop_front();
    checks++;
    if (got_pc !== want_pc || bus.ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ret: pc/unf got 0x%h/%b want 0x%h/0", got_pc, bus.ras_underflow, want_pc);
    end
    $display("wrap_ret: pc=0x%h", got_pc);
  endtask

  task automatic test_halt();
    op_t o;
    restart();
    goto_pc(32'h7);
    o = '{ack: 1'b1, br: 1'b1, cl: 1'b0, rt: 1'b0, hl: 1'b1, st: 1'b1, tgt: 32'h99, exp: 32'h7};
    apply(o);
    got_pc  = bus.pc;
    want_pc = exp_q.pop_front();
    checks++;
    if (got_pc !== want_pc || bus.imem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: pc/req/busy got 0x%h/%b/%b want 0x%h/0/0",
               got_pc, bus.imem_req, bus.busy, want_pc);
    end
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      o = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h0, exp: 32'h7};
      apply(o);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc || bus.imem_req !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold: pc/req/busy got 0x%h/%b/%b want 0x%h/0/0",
                 got_pc, bus.imem_req, bus.busy, want_pc);
      end
      $display("halt: pc=0x%h req=%b", got_pc, bus.imem_req);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    restart();
    goto_pc(32'h33);
    bus.imem_ack = 1'b0;
    reset        = 1'b1;
    step();
    checks++;
    if (bus.pc !== 32'h0 || bus.imem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch: pc/req/busy got 0x%h/%b/%b want 0x0/0/0",
               bus.pc, bus.imem_req, bus.busy);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0) begin
      errors++;
      $display("FAIL idle_after_reset: pc/req got 0x%h/%b want 0x0/0", bus.pc, bus.imem_req);
    end
    $display("reset_mid_fetch: pc=0x%h req=%b", bus.pc, bus.imem_req);
  endtask

  task automatic test_back_to_back();
    op_t ops[7];
    restart();
    ops[0] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h0,  exp: 32'h1};
    ops[1] = '{ack: 1'b1, br: 1'b1, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h80, exp: 32'h80};
    ops[2] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h0,  exp: 32'h81};
    ops[3] = '{ack: 1'b1, br: 1'b1, cl: 1'b1, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h90, exp: 32'h90};
    ops[4] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h0,  exp: 32'h91};
    ops[5] = '{ack: 1'b1, br: 1'b1, cl: 1'b0, rt: 1'b1, hl: 1'b0, st: 1'b0, tgt: 32'hAA, exp: 32'h82};
    ops[6] = '{ack: 1'b1, br: 1'b0, cl: 1'b0, rt: 1'b0, hl: 1'b0, st: 1'b0, tgt: 32'h0,  exp: 32'h83};
    for (int i = 0; i < 7; i++) begin
      apply(ops[i]);
      got_pc  = bus.pc;
      want_pc = exp_q.pop_front();
      checks++;
      if (got_pc !== want_pc || bus.imem_req !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: pc/req got 0x%h/%b want 0x%h/1", i, got_pc, bus.imem_req, want_pc);
      end
      $display("b2b[%0d]: pc=0x%h req=%b", i, got_pc, bus.imem_req);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_wait_stall();
    test_call_ret();
    test_overflow();
    test_call_and_ret();
    test_wrap();
    test_halt();
    test_reset_mid_fetch();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: entries left got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
